// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor, the PLL wrapper and the downstream clock domains.
// Defining LOCK_LOSS_COUNTER_EN adds the lock_loss_cnt status field.
interface pll_lock_supervisor_if #(
  parameter int unsigned NUM_DOMAINS = 2
);
  logic                   pll_locked;
  logic                   retry_req;
  logic                   pll_rst;
  logic [NUM_DOMAINS-1:0] domain_rst_n;
  logic                   ready;
  logic                   fail;
  logic [3:0]             retry_cnt;
`ifdef LOCK_LOSS_COUNTER_EN
  logic [7:0]             lock_loss_cnt;
`endif

  // Supervisor side
  modport master (
    input  pll_locked,
    input  retry_req,
    output pll_rst,
    output domain_rst_n,
    output ready,
    output fail,
    output retry_cnt
`ifdef LOCK_LOSS_COUNTER_EN
    , output lock_loss_cnt
`endif
  );

  // PLL wrapper / clock-domain side
  modport slave (
    output pll_locked,
    output retry_req,
    input  pll_rst,
    input  domain_rst_n,
    input  ready,
    input  fail,
    input  retry_cnt
`ifdef LOCK_LOSS_COUNTER_EN
    , input lock_loss_cnt
`endif
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL reset / lock supervisor: sequences PLL reset, qualifies lock and releases domain resets in order.
// Optional macro LOCK_LOSS_COUNTER_EN adds a saturating RUN->PLL_RST lock-loss counter.
module pll_lock_supervisor #(
  parameter int unsigned NUM_DOMAINS      = 2,
  parameter int unsigned PLL_RST_CYC      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 40000,
  parameter int unsigned LOCK_STABLE_CYC  = 4000,
  parameter int unsigned RELEASE_GAP_CYC  = 64,
  parameter int unsigned MAX_RETRY        = 3
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  pll_lock_supervisor_if.master bus
);

  localparam int unsigned RST_W = (PLL_RST_CYC      > 1) ? $clog2(PLL_RST_CYC)      : 1;
  localparam int unsigned TO_W  = (LOCK_TIMEOUT_CYC > 1) ? $clog2(LOCK_TIMEOUT_CYC) : 1;
  localparam int unsigned STB_W = (LOCK_STABLE_CYC  > 1) ? $clog2(LOCK_STABLE_CYC)  : 1;
  localparam int unsigned GAP_W = (RELEASE_GAP_CYC  > 1) ? $clog2(RELEASE_GAP_CYC)  : 1;
  localparam int unsigned RTY_W = 4;

  localparam logic [RST_W-1:0] RST_LAST  = RST_W'(PLL_RST_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [STB_W-1:0] STB_LAST  = STB_W'(LOCK_STABLE_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(RELEASE_GAP_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRY);
  localparam logic [RTY_W-1:0] RTY_MAX   = '1;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } state_e;

  // A single domain has nothing to sequence, so lock qualification lands directly in RUN.
  localparam state_e REL_ENTRY = (NUM_DOMAINS == 1) ? ST_RUN : ST_RELEASE;

  logic [1:0]             rst_sync_q;
  logic                   run_en;
  logic                   lock_meta_q;
  logic                   locked_s;

  state_e                 state_q, state_d;
  logic [RST_W-1:0]       rst_cnt_q, rst_cnt_d;
  logic [TO_W-1:0]        to_cnt_q,  to_cnt_d;
  logic [STB_W-1:0]       stb_cnt_q, stb_cnt_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic [RTY_W-1:0]       retry_q,   retry_d;
  logic [RTY_W-1:0]       retry_inc;

  logic                   pll_rst_q, pll_rst_d;
  logic [NUM_DOMAINS-1:0] dom_q,     dom_d;
  logic [NUM_DOMAINS-1:0] dom_shift;
  logic                   gap_done;
  logic                   ready_q,   ready_d;
  logic                   fail_q,    fail_d;

  // Reset deassertion and the raw lock flag both cross into refclk through two flops.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q  <= 2'b00;
      lock_meta_q <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      rst_sync_q  <= {rst_sync_q[0], 1'b1};
      lock_meta_q <= bus.pll_locked;
      locked_s    <= lock_meta_q;
    end
  end

  assign run_en    = rst_sync_q[1];
  assign retry_inc = (retry_q == RTY_MAX) ? retry_q : retry_q + RTY_W'(1);
  assign dom_shift = NUM_DOMAINS'({dom_q, 1'b1});
  assign gap_done  = (gap_cnt_q == GAP_LAST);

  // State register, counters and registered outputs
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_PLL_RST;
      rst_cnt_q <= '0;
      to_cnt_q  <= '0;
      stb_cnt_q <= '0;
      gap_cnt_q <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      dom_q     <= '0;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      to_cnt_q  <= to_cnt_d;
      stb_cnt_q <= stb_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      dom_q     <= dom_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end

  // Next-state and counter update; counters stop at their terminal value and clear when idle.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = '0;
    to_cnt_d  = '0;
    stb_cnt_d = '0;
    gap_cnt_d = '0;
    retry_d   = retry_q;

    if (!run_en) begin
      state_d = ST_PLL_RST;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (rst_cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
          else                       rst_cnt_d = rst_cnt_q + RST_W'(1);
        end

        // Lock seen on the timeout cycle wins over the timeout.
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            if (LOCK_STABLE_CYC <= 1) begin
              state_d = REL_ENTRY;
            end else begin
              state_d   = ST_STABLE;
              stb_cnt_d = STB_W'(1);
            end
          end else if (to_cnt_q == TO_LAST) begin
            retry_d = retry_inc;
            state_d = (retry_inc >= RTY_LIMIT) ? ST_FAIL : ST_PLL_RST;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end

        ST_STABLE: begin
          if (!locked_s)                  state_d = ST_WAIT_LOCK;
          else if (stb_cnt_q == STB_LAST) state_d = REL_ENTRY;
          else                            stb_cnt_d = stb_cnt_q + STB_W'(1);
        end

        ST_RELEASE: begin
          if (!locked_s) begin
            state_d = ST_PLL_RST;
          end else if (gap_done) begin
            if (&dom_shift) state_d = ST_RUN;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end

        ST_RUN: begin
          if (!locked_s) state_d = ST_PLL_RST;
        end

        ST_FAIL: begin
          if (bus.retry_req) begin
            state_d = ST_PLL_RST;
            retry_d = '0;
          end
        end

        default: state_d = ST_PLL_RST;
      endcase

      if (state_d == ST_RUN) retry_d = '0;
    end
  end

  // Registered-output next values, decoded from the upcoming state.
  always_comb begin
    pll_rst_d = (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
    fail_d    = (state_d == ST_FAIL);
    ready_d   = (state_d == ST_RUN);
    dom_d     = '0;
    case (state_d)
      ST_RELEASE: begin
        if (state_q != ST_RELEASE) dom_d = NUM_DOMAINS'(1);
        else if (gap_done)         dom_d = dom_shift;
        else                       dom_d = dom_q;
      end
      ST_RUN:  dom_d = '1;
      default: dom_d = '0;
    endcase
  end

`ifdef LOCK_LOSS_COUNTER_EN
  logic [7:0] loss_cnt_q;

  // Counts RUN->PLL_RST transitions; only rst_n clears it.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt_q <= '0;
    end else if ((state_q == ST_RUN) && (state_d == ST_PLL_RST) && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_q <= loss_cnt_q + 8'd1;
    end
  end

  assign bus.lock_loss_cnt = loss_cnt_q;
`endif

  // Domain resets and ready drop in the very cycle synchronised lock is lost,
  // ahead of the registered state catching up on the next edge.
  assign bus.pll_rst      = pll_rst_q;
  assign bus.domain_rst_n = dom_q & {NUM_DOMAINS{locked_s}};
  assign bus.ready        = ready_q & locked_s;
  assign bus.fail         = fail_q;
  assign bus.retry_cnt    = retry_q;

endmodule
